// File: rtl/alu_pkg.sv
// alu_pkg: shared ALU opcode encodings, op type and default datapath width
package alu_pkg;
  localparam int ALU_WIDTH = 32;
  typedef logic [1:0] alu_op_t;
  localparam alu_op_t ALU_OP_AND  = 2'b00;
  localparam alu_op_t ALU_OP_OR   = 2'b01;
  localparam alu_op_t ALU_OP_XOR  = 2'b10;
  localparam alu_op_t ALU_OP_XNOR = 2'b11;
endpackage

// File: rtl/alu_bitwise_units.sv
// alu_bitwise_units: per-function 32-bit bitwise units (and_32, or_32, xor_32, xnor_32)
module and_32 #(parameter int W = 32) (
  input  logic [0:W-1] a,
  input  logic [0:W-1] b,
  output logic [0:W-1] z
);
  assign z = a & b;
endmodule

module or_32 #(parameter int W = 32) (
  input  logic [0:W-1] a,
  input  logic [0:W-1] b,
  output logic [0:W-1] z
);
  assign z = a | b;
endmodule

module xor_32 #(parameter int W = 32) (
  input  logic [0:W-1] a,
  input  logic [0:W-1] b,
  output logic [0:W-1] z
);
  assign z = a ^ b;
endmodule

module xnor_32 #(parameter int W = 32) (
  input  logic [0:W-1] a,
  input  logic [0:W-1] b,
  output logic [0:W-1] z
);
  assign z = ~(a ^ b);
endmodule

// File: rtl/alu_skid_buf.sv
// alu_skid_buf: main+skid register pair sustaining one transfer per cycle with a registered in_ready
module alu_skid_buf #(
  parameter int           P       = 8,
  parameter logic [P-1:0] RST_VAL = '0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [P-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [P-1:0] out_data
);
  logic         skid_valid;
  logic [P-1:0] skid_data;
  logic         free, accept;
  assign free     = ~out_valid | out_ready;
  assign accept   = in_valid & in_ready;
  assign in_ready = ~skid_valid;
  // main register: refill from the skid first so order stays FIFO, else from the input
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= RST_VAL;
    end else if (free) begin
      out_valid <= skid_valid | accept;
      out_data  <= skid_valid ? skid_data : accept ? in_data : out_data;
    end
  // skid register: holds the one op accepted while main is stalled
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      skid_valid <= 1'b0;
      skid_data  <= RST_VAL;
    end else if (free) begin
      skid_valid <= 1'b0;
    end else if (accept) begin
      skid_valid <= 1'b1;
      skid_data  <= in_data;
    end
endmodule

// File: rtl/alu_logic_stage.sv
// alu_logic_stage: registered AND/OR/XOR/XNOR stage with skid buffering; ALU_LOGIC_ZERO_FLAG_EN adds out_zero
module alu_logic_stage
  import alu_pkg::*;
#(
  parameter int WIDTH = ALU_WIDTH,
  parameter int TAG_W = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  alu_op_t          in_op,
  input  logic [0:WIDTH-1] in_x,
  input  logic [0:WIDTH-1] in_y,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [0:WIDTH-1] out_z,
  output logic [TAG_W-1:0] out_tag
`ifdef ALU_LOGIC_ZERO_FLAG_EN
  ,
  output logic             out_zero
`endif
);
`ifdef ALU_LOGIC_ZERO_FLAG_EN
  localparam int ZW = 1;
`else
  localparam int ZW = 0;
`endif
  localparam int PW = TAG_W + WIDTH + ZW;
  logic [0:WIDTH-1] and_z, or_z, xor_z, xnor_z, res;
  logic [PW-1:0]    pin, pout;
  and_32  #(.W(WIDTH)) u_and  (.a(in_x), .b(in_y), .z(and_z));
  or_32   #(.W(WIDTH)) u_or   (.a(in_x), .b(in_y), .z(or_z));
  xor_32  #(.W(WIDTH)) u_xor  (.a(in_x), .b(in_y), .z(xor_z));
  xnor_32 #(.W(WIDTH)) u_xnor (.a(in_x), .b(in_y), .z(xnor_z));
  // pick the unit output named by the opcode
  always_comb
    res = in_op == ALU_OP_AND ? and_z :
          in_op == ALU_OP_OR  ? or_z  :
          in_op == ALU_OP_XOR ? xor_z : xnor_z;
`ifdef ALU_LOGIC_ZERO_FLAG_EN
  assign pin = {in_tag, res, ~|res};
  assign {out_tag, out_z, out_zero} = pout;
`else
  assign pin = {in_tag, res};
  assign {out_tag, out_z} = pout;
`endif
  alu_skid_buf #(.P(PW), .RST_VAL(PW'(ZW))) u_buf (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (pin),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (pout)
  );
endmodule
